// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode and ALU-control constants,
// the issue-entry record carried through the skid buffer, and the buffer states.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALUC_ADD  = 5'b00000;
    localparam logic [4:0] ALUC_SLL  = 5'b00001;
    localparam logic [4:0] ALUC_SLT  = 5'b00010;
    localparam logic [4:0] ALUC_SLTU = 5'b00011;
    localparam logic [4:0] ALUC_XOR  = 5'b00100;
    localparam logic [4:0] ALUC_SRL  = 5'b00101;
    localparam logic [4:0] ALUC_OR   = 5'b00110;
    localparam logic [4:0] ALUC_AND  = 5'b00111;
    localparam logic [4:0] ALUC_SUB  = 5'b01000;
    localparam logic [4:0] ALUC_SRA  = 5'b01101;
    localparam logic [4:0] ALUC_BEQ  = 5'b10000;
    localparam logic [4:0] ALUC_BNE  = 5'b10001;
    localparam logic [4:0] ALUC_BGEU = 5'b10011;
    localparam logic [4:0] ALUC_BLT  = 5'b10100;
    localparam logic [4:0] ALUC_BGE  = 5'b10101;
    localparam logic [4:0] ALUC_BLTU = 5'b10110;
    localparam logic [4:0] ALUC_JUMP = 5'b11111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  aluc;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] target;
        logic        illegal;
    } issue_entry_t;

    localparam int ENTRY_W = $bits(issue_entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Register-register and register-immediate codes are {0, alt, funct3};
    // the alternate bit (instr[30]) only distinguishes SUB and SRA.
    function automatic logic [4:0] alu_op_code(input logic [2:0] funct3, input logic alt);
        logic w_alt;
        w_alt = alt && (funct3 == 3'b000 || funct3 == 3'b101);
        return {1'b0, w_alt, funct3};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder: turns an instruction, its pc and the register
// read data into one issue entry (operands, ALU code, destination, target).
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]        i_instr,
    input  logic [31:0]        i_pc,
    input  logic [31:0]        i_rs1_data,
    input  logic [31:0]        i_rs2_data,
    output logic [ENTRY_W-1:0] o_entry
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [4:0]   w_rd;
    logic [31:0]  w_shamt;
    logic [31:0]  w_imm_i;
    logic [31:0]  w_imm_u;
    logic [31:0]  w_imm_b;
    logic [31:0]  w_imm_j;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_jalr_sum;
    issue_entry_t w_e;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_rd       = i_instr[11:7];
    assign w_shamt    = {27'd0, i_instr[24:20]};
    assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_u    = {i_instr[31:12], 12'd0};
    assign w_imm_b    = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_j    = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign w_pc_plus4 = i_pc + 32'd4;
    assign w_jalr_sum = i_rs1_data + w_imm_i;

    always_comb begin
        w_e = '0;
        case (w_opcode)
            OPC_OP: begin
                w_e.aluc = alu_op_code(w_funct3, i_instr[30]);
                if (w_e.aluc == ALUC_SUB || w_e.aluc == ALUC_SLL) begin
                    w_e.a = i_rs2_data;
                    w_e.b = i_rs1_data;
                end else begin
                    w_e.a = i_rs1_data;
                    w_e.b = i_rs2_data;
                end
                w_e.rd    = w_rd;
                w_e.rd_we = (w_rd != 5'd0);
            end
            OPC_OP_IMM: begin
                // Only shifts use instr[30] as an opcode bit; ADDI has no SUB form.
                w_e.aluc = alu_op_code(w_funct3, i_instr[30] && (w_funct3 == 3'b101));
                if (w_funct3 == 3'b001) begin
                    w_e.a = w_shamt;
                    w_e.b = i_rs1_data;
                end else if (w_funct3 == 3'b101) begin
                    w_e.a = i_rs1_data;
                    w_e.b = w_shamt;
                end else begin
                    w_e.a = i_rs1_data;
                    w_e.b = w_imm_i;
                end
                w_e.rd    = w_rd;
                w_e.rd_we = (w_rd != 5'd0);
            end
            OPC_LUI: begin
                w_e.aluc  = ALUC_ADD;
                w_e.b     = w_imm_u;
                w_e.rd    = w_rd;
                w_e.rd_we = (w_rd != 5'd0);
            end
            OPC_AUIPC: begin
                w_e.aluc  = ALUC_ADD;
                w_e.a     = i_pc;
                w_e.b     = w_imm_u;
                w_e.rd    = w_rd;
                w_e.rd_we = (w_rd != 5'd0);
            end
            OPC_BRANCH: begin
                w_e.a      = i_rs1_data;
                w_e.b      = i_rs2_data;
                w_e.target = i_pc + w_imm_b;
                case (w_funct3)
                    3'b000:  w_e.aluc = ALUC_BEQ;
                    3'b001:  w_e.aluc = ALUC_BNE;
                    3'b100:  w_e.aluc = ALUC_BLT;
                    3'b101:  w_e.aluc = ALUC_BGE;
                    3'b110:  w_e.aluc = ALUC_BLTU;
                    3'b111:  w_e.aluc = ALUC_BGEU;
                    default: w_e = '{default: '0, illegal: 1'b1};
                endcase
            end
            OPC_JAL: begin
                w_e.aluc   = ALUC_JUMP;
                w_e.a      = w_pc_plus4;
                w_e.target = i_pc + w_imm_j;
                w_e.rd     = w_rd;
                w_e.rd_we  = (w_rd != 5'd0);
            end
            OPC_JALR: begin
                w_e.aluc   = ALUC_JUMP;
                w_e.a      = w_pc_plus4;
                w_e.target = {w_jalr_sum[31:1], 1'b0};
                w_e.rd     = w_rd;
                w_e.rd_we  = (w_rd != 5'd0);
            end
            default: begin
                w_e.illegal = 1'b1;
            end
        endcase
    end

    assign o_entry = w_e;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the offered instruction and holds up to two decoded
// entries in a skid buffer; the outputs always show the head entry.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] A_o,
    output logic [31:0] B_o,
    output logic [4:0]  aluc_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic [31:0] target_o,
    output logic        illegal_o,
    output logic [1:0]  state_o
);

    // Handshake: an entry moves on a cycle where valid and ready are both high
    // at the rising edge; valid never waits on ready, and flush beats both.
    skid_state_e  r_state;
    skid_state_e  w_next_state;
    issue_entry_t r_head;
    issue_entry_t r_tail;
    issue_entry_t w_dec;
    logic         r_in_ready;
    logic         w_accept;
    logic         w_issue;

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    alu_decode u_decode (
        .i_instr    (instr_i),
        .i_pc       (pc_i),
        .i_rs1_data (rs1_data_i),
        .i_rs2_data (rs2_data_i),
        .o_entry    (w_dec)
    );

    assign w_accept = in_valid_i && r_in_ready;
    assign w_issue  = (r_state != ST_EMPTY) && out_ready_i;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_issue) w_next_state = ST_FULL;
                else if (w_issue && !w_accept) w_next_state = ST_EMPTY;
            end
            ST_FULL:  if (w_issue) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
        if (flush_i) w_next_state = ST_EMPTY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Ready is low whenever FULL, so FULL never sees an accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!flush_i) begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_head <= w_dec;
                ST_ONE: begin
                    if (w_accept && w_issue) r_head <= w_dec;
                    else if (w_accept) r_tail <= w_dec;
                end
                ST_FULL:  if (w_issue) r_head <= r_tail;
                default: ;
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state != ST_EMPTY);
    assign A_o         = r_head.a;
    assign B_o         = r_head.b;
    assign aluc_o      = r_head.aluc;
    assign rd_o        = r_head.rd;
    assign rd_we_o     = r_head.rd_we;
    assign target_o    = r_head.target;
    assign illegal_o   = r_head.illegal;
    assign state_o     = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed instruction and handshake cases followed
// by randomized traffic, checked by a reference model through an expected queue.
module tb_alu_issue_stage;

  localparam int W = 108;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] A_o;
  logic [31:0] B_o;
  logic [4:0]  aluc_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic [31:0] target_o;
  logic        illegal_o;
  logic [1:0]  state_o;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit tracking = 0;

  alu_issue_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .A_o         (A_o),
    .B_o         (B_o),
    .aluc_o      (aluc_o),
    .rd_o        (rd_o),
    .rd_we_o     (rd_we_o),
    .target_o    (target_o),
    .illegal_o   (illegal_o),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what the spec says each instruction issues as,
  // packed as {A, B, aluc, rd, rd_we, target, illegal}.
  function automatic logic [W-1:0] ref_issue(input logic [31:0] ins, input logic [31:0] pc,
                                              input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] a = 0, b = 0, tgt = 0;
    logic [4:0]  code = 0, rd = 0;
    logic        we = 0, ill = 0;
    logic [2:0]  f3 = ins[14:12];
    logic [4:0]  reg_codes[8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    int imm_i, imm_b, imm_j;
    logic [31:0] imm_u, shamt, jsum;
    imm_i = (ins[31] ? -4096 : 0) + int'(ins[31:20]);
    imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    imm_u = ins & 32'hFFFF_F000;
    shamt = 32'(ins[24:20]);
    case (ins[6:0])
      7'h33: begin
        code = reg_codes[f3];
        if (ins[30] && f3 == 3'd0) code = 5'd8;
        if (ins[30] && f3 == 3'd5) code = 5'd13;
        if (code == 5'd8 || code == 5'd1) begin a = r2; b = r1; end
        else begin a = r1; b = r2; end
        rd = ins[11:7]; we = (rd != 0);
      end
      7'h13: begin
        code = reg_codes[f3];
        if (ins[30] && f3 == 3'd5) code = 5'd13;
        if (f3 == 3'd1) begin a = shamt; b = r1; end
        else if (f3 == 3'd5) begin a = r1; b = shamt; end
        else begin a = r1; b = 32'(imm_i); end
        rd = ins[11:7]; we = (rd != 0);
      end
      7'h37: begin b = imm_u; rd = ins[11:7]; we = (rd != 0); end
      7'h17: begin a = pc; b = imm_u; rd = ins[11:7]; we = (rd != 0); end
      7'h63: begin
        case (f3)
          3'd0: code = 5'b10000;
          3'd1: code = 5'b10001;
          3'd4: code = 5'b10100;
          3'd5: code = 5'b10101;
          3'd6: code = 5'b10110;
          3'd7: code = 5'b10011;
          default: ill = 1;
        endcase
        if (!ill) begin a = r1; b = r2; tgt = pc + 32'(imm_b); end
      end
      7'h6F: begin
        code = 5'b11111; a = pc + 4; tgt = pc + 32'(imm_j);
        rd = ins[11:7]; we = (rd != 0);
      end
      7'h67: begin
        code = 5'b11111; a = pc + 4;
        jsum = r1 + 32'(imm_i);
        tgt = jsum & 32'hFFFF_FFFE;
        rd = ins[11:7]; we = (rd != 0);
      end
      default: ill = 1;
    endcase
    return {a, b, code, rd, we, tgt, ill};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    logic [2:0]  br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0]  bad_op[5] = '{7'h03, 7'h23, 7'h0F, 7'h73, 7'h7F};
    int k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        ins[6:0] = 7'h33;
        ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      2, 3: begin
        ins[6:0] = 7'h13;
        if (ins[14:12] == 3'd1) ins[31:25] = 7'h00;
        if (ins[14:12] == 3'd5) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      4: ins[6:0] = 7'h37;
      5: ins[6:0] = 7'h17;
      6: begin ins[6:0] = 7'h63; ins[14:12] = br_f3[$urandom_range(0, 5)]; end
      7: ins[6:0] = 7'h6F;
      8: begin ins[6:0] = 7'h67; ins[14:12] = 3'd0; end
      default: ins[6:0] = bad_op[$urandom_range(0, 4)];
    endcase
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (tracking && !rst_i) begin
      chk("out_valid_vs_occupancy", 128'(out_valid_o), 128'(exp_q.size() != 0));
      chk("in_ready_vs_occupancy", 128'(in_ready_o), 128'(exp_q.size() < 2));
      chk("rs_addr", 128'({rs1_addr_o, rs2_addr_o}), 128'({instr_i[19:15], instr_i[24:20]}));
    end
    if (rst_i || flush_i) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        got = {A_o, B_o, aluc_o, rd_o, rd_we_o, target_o, illegal_o};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: got entry %h expected no issue", got);
        end else begin
          exp = exp_q.pop_front();
          chk("issued_entry", 128'(got), 128'(exp));
        end
      end
      if (in_valid_i && in_ready_o)
        exp_q.push_back(ref_issue(instr_i, pc_i, rs1_data_i, rs2_data_i));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_drain();
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 10 && out_valid_o; i++) step();
    chk("drain_done", 128'(out_valid_o), 128'(0));
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid_i = 1'b1;
    instr_i = ins;
    pc_i = pc;
    rs1_data_i = r1;
    rs2_data_i = r2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepts;
    rst_i = 1'b1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    instr_i = 32'h0;
    pc_i = 32'h0;
    rs1_data_i = 32'h0;
    rs2_data_i = 32'h0;
    step();
    step();
    rst_i = 1'b0;
    tracking = 1'b1;

    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(1));
    chk("rst_fields", 128'({A_o, B_o, target_o, aluc_o, rd_o, rd_we_o, illegal_o}), 128'(0));

    // ADDI x1,x0,5 from EMPTY shows next cycle
    out_ready_i = 1'b1;
    offer(32'h00500093, 32'h0, 32'h0, 32'h0);
    step();
    in_valid_i = 1'b0;
    chk("addi_valid", 128'(out_valid_o), 128'(1));
    chk("addi_AB", 128'({A_o, B_o}), 128'({32'd0, 32'd5}));
    chk("addi_ctl", 128'({aluc_o, rd_o, rd_we_o}), 128'({5'b00000, 5'd1, 1'b1}));

    // SUB x3,x1,x2 swaps operands
    offer(32'h402081B3, 32'h4, 32'd10, 32'd3);
    step();
    in_valid_i = 1'b0;
    chk("sub_AB", 128'({A_o, B_o}), 128'({32'd3, 32'd10}));
    chk("sub_ctl", 128'({aluc_o, rd_o}), 128'({5'b01000, 5'd3}));

    // BEQ x1,x2,+8 at 0x100
    offer(32'h00208463, 32'h100, 32'h11, 32'h22);
    step();
    in_valid_i = 1'b0;
    chk("beq_ctl", 128'({aluc_o, rd_we_o}), 128'({5'b10000, 1'b0}));
    chk("beq_target", 128'(target_o), 128'(32'h108));

    // Load opcode is unsupported
    offer(32'h00000003, 32'h8, 32'h5, 32'h6);
    step();
    in_valid_i = 1'b0;
    chk("load_illegal", 128'({illegal_o, rd_we_o, aluc_o}), 128'({1'b1, 1'b0, 5'b00000}));
    idle_drain();

    // Back-pressure: three offers with the ALU stalled
    out_ready_i = 1'b0;
    accepts = 0;
    for (int i = 0; i < 3; i++) begin
      offer(gen_instr(), 32'h200 + 32'(i * 4), $urandom, $urandom);
      if (in_ready_o) accepts++;
      step();
      if (i == 1) chk("bp_ready_low", 128'(in_ready_o), 128'(0));
    end
    in_valid_i = 1'b0;
    chk("bp_accepts", 128'(accepts), 128'(2));
    chk("bp_full_valid", 128'(out_valid_o), 128'(1));
    idle_drain();

    // Flush while FULL with a new offer
    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(gen_instr(), 32'h300 + 32'(i * 4), $urandom, $urandom);
      step();
    end
    chk("fl_pre_ready", 128'(in_ready_o), 128'(0));
    offer(32'h00500093, 32'h308, 32'h0, 32'h0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("fl_valid", 128'(out_valid_o), 128'(0));
    chk("fl_ready", 128'(in_ready_o), 128'(1));
    out_ready_i = 1'b1;
    step();
    step();

    // Reset mid-operation overrides handshakes
    out_ready_i = 1'b0;
    offer(gen_instr(), 32'h400, $urandom, $urandom);
    step();
    rst_i = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    step();
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    chk("mid_rst_valid", 128'(out_valid_o), 128'(0));
    chk("mid_rst_ready", 128'(in_ready_o), 128'(1));

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid_i = ($urandom_range(0, 3) != 0);
      instr_i = gen_instr();
      pc_i = $urandom & 32'hFFFF_FFFC;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_drain();
    step();
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Ports are listed as name, direction, width, meaning; clock and reset come first.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 flush_i  in  1  discards all buffered entries.
REQ-005 in_valid_i  in  1  instruction offered; in_ready_o  out  1  stage can accept (registered).
REQ-006 instr_i  in  32  RV32I instruction word; pc_i  in  32  its address.
REQ-007 rs1_addr_o / rs2_addr_o  out  5  combinational copies of instr_i[19:15] / instr_i[24:20].
REQ-008 rs1_data_i / rs2_data_i  in  32  register-file read data, valid in the same cycle.
REQ-009 out_valid_o  out  1  issued op valid; out_ready_i  in  1  ALU side accepts.
REQ-010 A_o, B_o  out  32  ALU operands; aluc_o  out  5  ALU control code.
REQ-011 rd_o  out  5  destination; rd_we_o  out  1  write enable; target_o  out  32  branch/jump target; illegal_o  out  1  unsupported opcode.

Function
REQ-012 The block shall decode opcodes OP, OP-IMM, LUI, AUIPC, BRANCH, JAL and JALR; every other opcode shall issue with illegal_o=1, aluc_o=00000, rd_we_o=0.
REQ-013 aluc encoding: ADD 00000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, OR 00110, AND 00111, SUB 01000, SRA 01101, BEQ 10000, BNE 10001, BGEU 10011, BLT 10100, BGE 10101, BLTU 10110, JAL/JALR 11111.
REQ-014 Branch codes shall always have aluc_o[4:3]=10; no non-branch code shall.
REQ-015 Operand order: default A=rs1, B=rs2 or immediate; SUB: A=rs2, B=rs1; SLL/SLLI: A=shamt or rs2, B=rs1.
REQ-016 LUI: A=0, B=U-imm, ADD; AUIPC: A=pc, B=U-imm, ADD.
REQ-017 JAL/JALR: A=pc+4, B=0, aluc=11111, rd_we_o=1.
REQ-018 target_o: BRANCH/JAL = pc+sign-extended imm; JALR = (rs1+imm) with bit 0 cleared; otherwise 0.
REQ-019 rd_we_o shall be 0 for BRANCH, illegal, and rd=x0; 1 otherwise.
REQ-020 Immediates shall be sign-extended to 32 bits; all additions modulo 2^32.
REQ-021 Buffering: two-entry skid buffer with states EMPTY, ONE, FULL; outputs always driven from the head entry.
REQ-022 Accept occurs when in_valid_i && in_ready_o; issue occurs when out_valid_o && out_ready_i.
REQ-023 in_ready_o shall be 1 in EMPTY and ONE, and 0 in FULL.
REQ-024 Transitions: EMPTY+accept->ONE; ONE+accept without issue->FULL; ONE+issue without accept->EMPTY; ONE with both accept and issue stays ONE; FULL+issue->ONE.
REQ-025 Latency: an instruction accepted in EMPTY shall appear on the outputs the next cycle.
REQ-026 Order shall be preserved; no entry is dropped or duplicated except by flush or reset.
REQ-027 Output fields shall hold stable while out_valid_o=1 and out_ready_i=0.
REQ-028 flush_i has priority over accept and issue: the next state is EMPTY, and an instruction offered in the flush cycle is discarded.

Reset
REQ-029 While rst_i=1 at a clock edge, the state shall become EMPTY.
REQ-030 Reset values: out_valid_o=0, in_ready_o=1, A_o=B_o=target_o=0, aluc_o=00000, rd_o=0, rd_we_o=0, illegal_o=0.
REQ-031 Reset mid-operation shall discard all entries; reset overrides flush_i and all handshake inputs.

Structure
REQ-032 A shared package alu_pkg shall hold the aluc code constants, RV32I opcode constants, and the issue-entry struct typedef.
REQ-033 The combinational decoder shall be a sub-module alu_decode (instr, pc, rs1/rs2 data -> entry), instanced once ahead of the skid buffer.

Verification
REQ-034 ADDI x1,x0,5: instr 0x00500093, rs1_data 0, accepted in EMPTY -> next cycle A=0, B=5, aluc=00000, rd=1, rd_we=1.
REQ-035 SUB x3,x1,x2: instr 0x402081B3, rs1=10, rs2=3 -> A=3, B=10, aluc=01000, rd=3.
REQ-036 BEQ x1,x2,+8: instr 0x00208463 at pc 0x100 -> aluc=10000, rd_we=0, target=0x108.
REQ-037 Back-pressure: in_valid_i=1 every cycle with out_ready_i=0 for 3 cycles -> exactly 2 accepted, in_ready_o=0 from the cycle after the second accept, in-order issue after release.
REQ-038 FULL plus flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed instruction never issued.
REQ-039 Load 0x00000003 -> illegal_o=1, rd_we_o=0, aluc=00000.
